// File: rtl/cory_packn_pkg.sv
// Shared constants and elaboration-time helpers for the N-lane packer.
package cory_packn_pkg;

   // Default geometry: four byte-wide lanes.
   localparam int DEF_CH = 4;
   localparam int DEF_W  = 8;

   // Width of a packed frame built from ch lanes of w bits each.
   function automatic int frame_width(input int ch, input int w);
      return ch * w;
   endfunction

   // Low bit index of lane k inside a packed vector of w-bit lanes.
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/cory_packn_lane.sv
// One collect lane: accepts at most one beat per frame and holds it until the
// frame moves into the output register.
module cory_packn_lane
   import cory_packn_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         msk,    // lane is part of the frame being collected
   input  logic         full,   // every enabled lane of the frame has its beat
   input  logic         xfer,   // frame moves to the output register this cycle
   input  logic         valid,
   input  logic [W-1:0] data,
   output logic         ready,
   output logic         got,
   output logic [W-1:0] cap
);

   logic hs;

   // Ready depends only on registered state and the mask; it is held low during reset.
   assign ready = msk & ~got & ~full & ~reset;
   assign hs    = valid & ready;

   // Per-lane "beat captured" flag, cleared when the frame is transferred.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of block evaluation order.
      if (reset) begin
         got <= 1'b0;
      end else if (xfer) begin
         got <= 1'b0;
      end else if (hs) begin
         got <= 1'b1;
      end
   end

   // Capture register loaded only on this lane's handshake.
   always_ff @(posedge clk) begin
      // NOTE: the data register has no reset; its content is only observed
      // through the mask, and disabled lanes are zero-forced downstream.
      if (hs) begin
         cap <= data;
      end
   end

endmodule

// File: rtl/cory_packn.sv
// N-lane valid/ready packer: collects one beat from each enabled lane in any
// order, then moves the whole frame into a double-buffered output register.
module cory_packn
   import cory_packn_pkg::*;
#(
   parameter int CH = DEF_CH,
   parameter int W  = DEF_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [CH-1:0]   i_en,
   input  logic [CH-1:0]   i_a_v,
   input  logic [CH*W-1:0] i_a_d,
   output logic [CH-1:0]   o_a_r,
   output logic            o_z_v,
   output logic [CH*W-1:0] o_z_d,
   output logic [CH-1:0]   o_z_m,
   input  logic            i_z_r
);

   localparam int Z = frame_width(CH, W);

   logic [CH-1:0]  got;
   logic [CH-1:0]  msk;
   logic [CH-1:0]  hs;
   logic [CH-1:0]  mask_q;
   logic [W-1:0]   cap [CH];
   logic [Z-1:0]   frame_d;
   logic           any_got;
   logic           full;
   logic           xfer;

   // Until the first beat of a frame lands, the live enable mask steers
   // readiness; afterwards the frozen mask does.
   assign any_got = |got;
   assign msk     = any_got ? mask_q : i_en;
   assign hs      = i_a_v & o_a_r;

   // Frame complete when a non-empty mask has all of its lanes captured.
   assign full = (|mask_q) & (&(got | ~mask_q));
   assign xfer = full & (~o_z_v | i_z_r);

   for (genvar k = 0; k < CH; k++) begin : g_lane
      cory_packn_lane #(
         .W (W)
      ) u_lane (
         .clk   (clk),
         .reset (reset),
         .msk   (msk[k]),
         .full  (full),
         .xfer  (xfer),
         .valid (i_a_v[k]),
         .data  (i_a_d[lane_lo(k, W) +: W]),
         .ready (o_a_r[k]),
         .got   (got[k]),
         .cap   (cap[k])
      );
   end

   // Assemble the outgoing frame, zero-filling lanes outside the frame mask.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      frame_d = '0;
      for (int k = 0; k < CH; k++) begin
         if (mask_q[k]) begin
            frame_d[lane_lo(k, W) +: W] = cap[k];
         end
      end
   end

   // Freeze the enable mask on the first handshake of a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
      end else if (!any_got && (|hs)) begin
         mask_q <= i_en;
      end
   end

   // Output register: load on transfer, drop valid on a handshake with no refill.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_z_v <= 1'b0;
         o_z_d <= '0;
         o_z_m <= '0;
      end else if (xfer) begin
         o_z_v <= 1'b1;
         o_z_d <= frame_d;
         o_z_m <= mask_q;
      end else if (o_z_v && i_z_r) begin
         o_z_v <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cory_packn.sv
// Directed bench for cory_packn with CH=4, W=8: a table of single-cycle frames
// followed by hand-written multi-cycle sequences.
module tb_cory_packn;

   localparam int CH = 4;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH-1:0]   i_en;
   logic [CH-1:0]   i_a_v;
   logic [CH*W-1:0] i_a_d;
   logic [CH-1:0]   o_a_r;
   logic            o_z_v;
   logic [CH*W-1:0] o_z_d;
   logic [CH-1:0]   o_z_m;
   logic            i_z_r;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  v;
      logic [31:0] d;
      logic [31:0] exp_d;
      logic [3:0]  exp_m;
   } vec_t;

   vec_t vecs [4];

   cory_packn #(
      .CH (CH),
      .W  (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .i_en  (i_en),
      .i_a_v (i_a_v),
      .i_a_d (i_a_d),
      .o_a_r (o_a_r),
      .o_z_v (o_z_v),
      .o_z_d (o_z_d),
      .o_z_m (o_z_m),
      .i_z_r (i_z_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{en: 4'hF, v: 4'hF, d: 32'h44332211, exp_d: 32'h44332211, exp_m: 4'hF};
      vecs[1] = '{en: 4'h5, v: 4'hF, d: 32'h44CC22AA, exp_d: 32'h00CC00AA, exp_m: 4'h5};
      vecs[2] = '{en: 4'h8, v: 4'h8, d: 32'hDEADBEEF, exp_d: 32'hDE000000, exp_m: 4'h8};
      vecs[3] = '{en: 4'h6, v: 4'hE, d: 32'h12345678, exp_d: 32'h00345600, exp_m: 4'h6};

      reset = 1'b1;
      i_en  = 4'hF;
      i_a_v = 4'h0;
      i_a_d = '0;
      i_z_r = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_z_v", 32'(o_z_v), 32'h0);
      check("rst_z_d", o_z_d, 32'h0);
      check("rst_z_m", 32'(o_z_m), 32'h0);
      check("rst_a_r", 32'(o_a_r), 32'h0);
      reset = 1'b0;
      i_en  = 4'h0;
      @(negedge clk);
      check("idle_no_en_rdy", 32'(o_a_r), 32'h0);

      // Table: every listed lane presents its beat in the same cycle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         i_en  = vecs[i].en;
         i_a_v = vecs[i].v;
         i_a_d = vecs[i].d;
         #1;
         check($sformatf("v%0d_rdy", i), 32'(o_a_r), 32'(vecs[i].en));
         @(negedge clk);
         i_a_v = 4'h0;
         check($sformatf("v%0d_full_rdy", i), 32'(o_a_r), 32'h0);
         check($sformatf("v%0d_no_early", i), 32'(o_z_v), 32'h0);
         @(negedge clk);
         check($sformatf("v%0d_z_v", i), 32'(o_z_v), 32'h1);
         check($sformatf("v%0d_z_d", i), o_z_d, vecs[i].exp_d);
         check($sformatf("v%0d_z_m", i), 32'(o_z_m), 32'(vecs[i].exp_m));
         @(negedge clk);
         check($sformatf("v%0d_drain", i), 32'(o_z_v), 32'h0);
      end

      // Lanes arrive one per cycle in order 2,0,3,1.
      @(negedge clk);
      i_en  = 4'hF;
      i_a_d = 32'h44332211;
      i_a_v = 4'b0100;
      #1;
      check("ord_rdy0", 32'(o_a_r), 32'hF);
      @(negedge clk);
      check("ord_rdy1", 32'(o_a_r), 32'hB);
      i_a_v = 4'b0001;
      @(negedge clk);
      check("ord_rdy2", 32'(o_a_r), 32'hA);
      i_a_v = 4'b1000;
      @(negedge clk);
      check("ord_rdy3", 32'(o_a_r), 32'h2);
      check("ord_no_early", 32'(o_z_v), 32'h0);
      i_a_v = 4'b0010;
      @(negedge clk);
      i_a_v = 4'h0;
      check("ord_full_rdy", 32'(o_a_r), 32'h0);
      check("ord_latency", 32'(o_z_v), 32'h0);
      @(negedge clk);
      check("ord_z_v", 32'(o_z_v), 32'h1);
      check("ord_z_d", o_z_d, 32'h44332211);
      check("ord_z_m", 32'(o_z_m), 32'hF);
      @(negedge clk);

      // Mask frozen after the first beat even though i_en changes.
      i_en  = 4'hF;
      i_a_v = 4'b0001;
      i_a_d = 32'h44332211;
      @(negedge clk);
      i_en  = 4'b0010;
      i_a_v = 4'h0;
      #1;
      check("frz_rdy", 32'(o_a_r), 32'hE);
      repeat (3) @(negedge clk);
      check("frz_wait_v", 32'(o_z_v), 32'h0);
      check("frz_wait_rdy", 32'(o_a_r), 32'hE);
      i_a_v = 4'hE;
      @(negedge clk);
      i_a_v = 4'h0;
      check("frz_no_early", 32'(o_z_v), 32'h0);
      @(negedge clk);
      check("frz_z_v", 32'(o_z_v), 32'h1);
      check("frz_z_d", o_z_d, 32'h44332211);
      check("frz_z_m", 32'(o_z_m), 32'hF);
      @(negedge clk);
      check("frz_drain", 32'(o_z_v), 32'h0);

      // Back-to-back frames with the consumer stalled.
      i_z_r = 1'b0;
      i_en  = 4'hF;
      i_a_v = 4'hF;
      i_a_d = 32'h0D0C0B0A;
      @(negedge clk);
      i_a_d = 32'h1D1C1B1A;
      check("bp_full_rdy", 32'(o_a_r), 32'h0);
      @(negedge clk);
      check("bp_a_v", 32'(o_z_v), 32'h1);
      check("bp_a_d", o_z_d, 32'h0D0C0B0A);
      check("bp_b_rdy", 32'(o_a_r), 32'hF);
      @(negedge clk);
      i_a_v = 4'h0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("bp_hold_v%0d", i), 32'(o_z_v), 32'h1);
         check($sformatf("bp_hold_d%0d", i), o_z_d, 32'h0D0C0B0A);
         check($sformatf("bp_stall_rdy%0d", i), 32'(o_a_r), 32'h0);
         @(negedge clk);
      end
      i_z_r = 1'b1;
      @(negedge clk);
      check("bp_b_v", 32'(o_z_v), 32'h1);
      check("bp_b_d", o_z_d, 32'h1D1C1B1A);
      check("bp_b_m", 32'(o_z_m), 32'hF);
      @(negedge clk);
      check("bp_drain", 32'(o_z_v), 32'h0);

      // Reset with a frame pending and two lanes of the next frame captured.
      i_z_r = 1'b0;
      i_a_v = 4'hF;
      i_a_d = 32'hC3C2C1C0;
      @(negedge clk);
      i_a_v = 4'h0;
      @(negedge clk);
      check("rmf_pre_v", 32'(o_z_v), 32'h1);
      i_a_v = 4'b0011;
      i_a_d = 32'hD3D2D1D0;
      @(negedge clk);
      i_a_v = 4'h0;
      reset = 1'b1;
      @(negedge clk);
      check("rmf_z_v", 32'(o_z_v), 32'h0);
      check("rmf_z_d", o_z_d, 32'h0);
      check("rmf_z_m", 32'(o_z_m), 32'h0);
      check("rmf_rdy", 32'(o_a_r), 32'h0);
      reset = 1'b0;
      i_z_r = 1'b1;
      i_a_v = 4'b1100;
      i_a_d = 32'hE3E2E1E0;
      @(negedge clk);
      i_a_v = 4'h0;
      check("rmf_post_rdy", 32'(o_a_r), 32'h3);
      @(negedge clk);
      check("rmf_discard", 32'(o_z_v), 32'h0);
      i_a_v = 4'b0011;
      i_a_d = 32'hF3F2F1F0;
      @(negedge clk);
      i_a_v = 4'h0;
      @(negedge clk);
      check("rmf_new_v", 32'(o_z_v), 32'h1);
      check("rmf_new_d", o_z_d, 32'hE3E2F1F0);
      check("rmf_new_m", 32'(o_z_m), 32'hF);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
